// File: rtl/ram_master.sv
// ram_master: burst master for a single-port RAM with combinational read data.
// Write bursts fill consecutive addresses with one word using a
// SETUP / STROBE / HOLD sequence so address and data are stable one cycle
// either side of the write strobe. Read bursts capture one word per
// SETUP / RCAP pair. The address pointer wraps modulo 256.
// Optional feature: define RAM_MASTER_RDBACK_EN to add a VCHK state after each
// written word. VCHK compares the RAM read-back against the fill word and sets a
// sticky err flag on mismatch. Without the macro, err is tied low.
module ram_master (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        rw,
    input  logic [7:0]  base_addr,
    input  logic [3:0]  len,
    input  logic [15:0] wdata,
    output logic        busy,
    output logic        ack,
    output logic        rvalid,
    output logic [15:0] rdata,
    output logic        err,
    output logic [7:0]  ram_addr,
    output logic [15:0] ram_din,
    output logic        ram_we,
    input  logic [15:0] ram_dout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_RCAP,
        S_DONE
`ifdef RAM_MASTER_RDBACK_EN
        , S_VCHK
`endif
    } state_t;

    state_t      state_q, state_d;
    logic        rw_q, rw_d;
    logic [15:0] wdata_q, wdata_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  ptr_q, ptr_d;

    logic        busy_q, busy_d;
    logic        ack_q, ack_d;
    logic        rvalid_q, rvalid_d;
    logic [15:0] rdata_q, rdata_d;
    logic [7:0]  ram_addr_q, ram_addr_d;
    logic [15:0] ram_din_q, ram_din_d;
    logic        ram_we_q, ram_we_d;

    logic        word_done;

`ifdef RAM_MASTER_RDBACK_EN
    logic        err_q, err_d;
`endif

    // Next-state logic; output registers are loaded from the next state so
    // every output already reflects the state it belongs to.
    always_comb begin
        state_d   = state_q;
        rw_d      = rw_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        rdata_d   = rdata_q;
        rvalid_d  = 1'b0;
        word_done = 1'b0;
`ifdef RAM_MASTER_RDBACK_EN
        err_d     = err_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    rw_d    = rw;
                    wdata_d = wdata;
                    cnt_d   = len;
                    ptr_d   = base_addr;
`ifdef RAM_MASTER_RDBACK_EN
                    err_d   = 1'b0;
`endif
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (rw_q) begin
                    state_d = S_STROBE;
                end else begin
                    // Read data is captured on the edge entering RCAP so
                    // that rvalid and the new rdata appear together in RCAP.
                    rdata_d  = ram_dout;
                    rvalid_d = 1'b1;
                    state_d  = S_RCAP;
                end
            end
            S_STROBE: begin
                state_d = S_HOLD;
            end
            S_HOLD: begin
`ifdef RAM_MASTER_RDBACK_EN
                state_d = S_VCHK;
`else
                word_done = 1'b1;
`endif
            end
`ifdef RAM_MASTER_RDBACK_EN
            S_VCHK: begin
                if (ram_dout != wdata_q) begin
                    err_d = 1'b1;
                end
                word_done = 1'b1;
            end
`endif
            S_RCAP: begin
                word_done = 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Shared end-of-word step for HOLD/VCHK and RCAP.
        if (word_done) begin
            if (cnt_q == '0) begin
                state_d = S_DONE;
            end else begin
                cnt_d   = cnt_q - 4'd1;
                ptr_d   = ptr_q + 8'd1;
                state_d = S_SETUP;
            end
        end

        busy_d     = (state_d != S_IDLE);
        ack_d      = (state_d == S_DONE);
        ram_we_d   = (state_d == S_STROBE);
        ram_addr_d = ptr_d;
        ram_din_d  = wdata_d;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rw_q       <= 1'b0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            ptr_q      <= '0;
            busy_q     <= 1'b0;
            ack_q      <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            ram_we_q   <= 1'b0;
`ifdef RAM_MASTER_RDBACK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rw_q       <= rw_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            busy_q     <= busy_d;
            ack_q      <= ack_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            ram_we_q   <= ram_we_d;
`ifdef RAM_MASTER_RDBACK_EN
            err_q      <= err_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign ack      = ack_q;
    assign rvalid   = rvalid_q;
    assign rdata    = rdata_q;
    assign ram_addr = ram_addr_q;
    assign ram_din  = ram_din_q;
    assign ram_we   = ram_we_q;
`ifdef RAM_MASTER_RDBACK_EN
    assign err      = err_q;
`else
    assign err      = 1'b0;
`endif

endmodule
